// File: rtl/misr_pkg.sv
// Shared types and the signature update function for the MISR capture block.
package misr_pkg;

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} misr_state_e;

  localparam int unsigned MISR_MAX_W = 64;
  localparam logic [7:0] MISR_POLY_DEF = 8'h1D;
  localparam logic [7:0] MISR_SEED_DEF = 8'h00;

  // One Galois step on a zero-extended signature of the given width.
  function automatic logic [MISR_MAX_W-1:0] misr_next(
    input logic [MISR_MAX_W-1:0] sig,
    input logic [MISR_MAX_W-1:0] data,
    input logic [MISR_MAX_W-1:0] poly,
    input int unsigned width
  );
    logic [MISR_MAX_W-1:0] mask;
    logic [MISR_MAX_W-1:0] shifted;
    logic msb;
    mask = (width >= MISR_MAX_W) ? {MISR_MAX_W{1'b1}}
                                 : ((MISR_MAX_W'(1) << width) - MISR_MAX_W'(1));
    msb = |(sig & (MISR_MAX_W'(1) << (width - 1)));
    shifted = (sig << 1) & mask;
    return shifted ^ (msb ? poly : {MISR_MAX_W{1'b0}}) ^ data;
  endfunction

endpackage

// File: rtl/misr_reg.sv
// Width-bit signature register: seed load, compression and (MISR_SCAN_EN) serial shift.
module misr_reg
  import misr_pkg::*;
#(
  parameter int unsigned      Width = 8,
  parameter logic [Width-1:0] Poly  = MISR_POLY_DEF,
  parameter logic [Width-1:0] Seed  = MISR_SEED_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             comp_i,
  input  logic [Width-1:0] data_i,
`ifdef MISR_SCAN_EN
  input  logic             shift_i,
  input  logic             scan_i,
`endif
  output logic [Width-1:0] sig_o
);

  logic [Width-1:0]      sig_q, sig_d;
  logic [MISR_MAX_W-1:0] sig_ext, data_ext, poly_ext, next_ext;
  logic                  unused_next_hi;

  always_comb begin
    sig_ext  = '0;
    data_ext = '0;
    poly_ext = '0;
    sig_ext[Width-1:0]  = sig_q;
    data_ext[Width-1:0] = data_i;
    poly_ext[Width-1:0] = Poly;
    next_ext = misr_next(sig_ext, data_ext, poly_ext, Width);
  end

  // Upper bits are always zero; folded here only so they count as consumed.
  assign unused_next_hi = ^next_ext;

  always_comb begin
    sig_d = sig_q;
`ifdef MISR_SCAN_EN
    if (shift_i) begin
      sig_d = {sig_q[Width-2:0], scan_i};
    end else
`endif
    if (load_i) begin
      sig_d = Seed;
    end else if (comp_i) begin
      sig_d = next_ext[Width-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sig_q <= Seed;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/misr_capture.sv
// MISR capture window: IDLE/CAPTURE/DONE control and sample counter around misr_reg.
// Optional serial scan access to the signature is enabled by defining MISR_SCAN_EN.
module misr_capture
  import misr_pkg::*;
#(
  parameter int unsigned      Width      = 8,
  parameter logic [Width-1:0] Poly       = MISR_POLY_DEF,
  parameter logic [Width-1:0] Seed       = MISR_SEED_DEF,
  parameter int unsigned      CaptureLen = 16,
  localparam int unsigned     CntW       = $clog2(CaptureLen + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             valid_i,
  input  logic [Width-1:0] data_i,
  input  logic             ack_i,
`ifdef MISR_SCAN_EN
  input  logic             scan_en_i,
  input  logic             scan_i,
  output logic             scan_o,
`endif
  output logic             busy_o,
  output logic             done_o,
  output logic [Width-1:0] sig_o,
  output logic [CntW-1:0]  cnt_o
);

  localparam logic [CntW-1:0] CapLen = CntW'(CaptureLen);

  misr_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            load, comp, freeze;

`ifdef MISR_SCAN_EN
  assign freeze = scan_en_i;
`else
  assign freeze = 1'b0;
`endif

  assign cnt_inc = cnt_q + CntW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    load    = 1'b0;
    comp    = 1'b0;
    if (!freeze) begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            state_d = CAPTURE;
            cnt_d   = '0;
            load    = 1'b1;
            busy_d  = 1'b1;
            done_d  = 1'b0;
          end
        end
        CAPTURE: begin
          if (valid_i) begin
            comp  = 1'b1;
            cnt_d = cnt_inc;
            // Leave on the edge that takes the last sample so DONE sees the final signature.
            if (cnt_inc == CapLen) begin
              state_d = DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end
        end
        DONE: begin
          if (ack_i) begin
            state_d = IDLE;
            done_d  = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  misr_reg #(
    .Width (Width),
    .Poly  (Poly),
    .Seed  (Seed)
  ) u_misr_reg (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (load),
    .comp_i  (comp),
    .data_i  (data_i),
`ifdef MISR_SCAN_EN
    .shift_i (scan_en_i),
    .scan_i  (scan_i),
`endif
    .sig_o   (sig_o)
  );

`ifdef MISR_SCAN_EN
  assign scan_o = sig_o[Width-1];
`endif

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign cnt_o  = cnt_q;

endmodule

// File: tb/tb_misr_capture.sv
// Directed and randomized bench for misr_capture with a GF(2) polynomial reference model.
module tb_misr_capture;

  localparam int W = 8;
  localparam int CL = 16;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       start_i = 1'b0;
  logic       valid_i = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic       ack_i = 1'b0;
  logic       busy_o, done_o;
  logic [7:0] sig_o;
  logic [4:0] cnt_o;
`ifdef MISR_SCAN_EN
  logic       scan_en_i = 1'b0;
  logic       scan_i = 1'b0;
  logic       scan_o;
`endif

  int tests = 0;
  int fails = 0;

  misr_capture #(
    .Width(W), .Poly(8'h1D), .Seed(8'h00), .CaptureLen(CL)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .valid_i(valid_i),
    .data_i(data_i), .ack_i(ack_i),
`ifdef MISR_SCAN_EN
    .scan_en_i(scan_en_i), .scan_i(scan_i), .scan_o(scan_o),
`endif
    .busy_o(busy_o), .done_o(done_o), .sig_o(sig_o), .cnt_o(cnt_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Signature as a polynomial over GF(2): sig*x mod (x^8+x^4+x^3+x^2+1), plus the sample.
  function automatic logic [7:0] gf_step(input logic [7:0] s, input logic [7:0] d);
    logic [8:0] t;
    t = {1'b0, s} << 1;
    if (t[8]) t = t ^ 9'h11D;
    return t[7:0] ^ d;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive at the falling edge, let one rising edge happen, sample at the next falling edge.
  task automatic step(input logic s, input logic v, input logic [7:0] d, input logic a);
    start_i = s; valid_i = v; data_i = d; ack_i = a;
    @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b0; valid_i = 1'b0; ack_i = 1'b0; data_i = 8'h00;
  endtask

  task automatic random_window(input int pct);
    logic [7:0] msig;
    int mcnt;
    int cyc;
    logic v;
    logic [7:0] d;
    msig = 8'h00;
    mcnt = 0;
    cyc = 0;
    step(1'b1, 1'b0, 8'h00, 1'b0);
    check("rnd_busy_after_start", busy_o, 1);
    while (mcnt < CL && cyc < 200) begin
      v = ($urandom_range(0, 99) < pct);
      d = 8'($urandom);
      step(1'b0, v, d, 1'b0);
      cyc++;
      if (v) begin
        msig = gf_step(msig, d);
        mcnt++;
      end
      check("rnd_sig", sig_o, msig);
      check("rnd_cnt", cnt_o, mcnt);
      check("rnd_done", done_o, (mcnt == CL));
    end
    check("rnd_window_finished", mcnt, CL);
    $display("[TB] random window pct=%0d cycles=%0d sig=%02h", pct, cyc, msig);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    check("rnd_ack_idle", done_o, 0);
  endtask

  initial begin
    logic [7:0] msig;
    logic [7:0] impulse_sig;

    #1;
    check("reset_sig", sig_o, 8'h00);
    check("reset_cnt", cnt_o, 0);
    check("reset_busy", busy_o, 0);
    check("reset_done", done_o, 0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Zero data window
    step(1'b0, 1'b1, 8'hA5, 1'b0);
    check("idle_ignores_valid", sig_o, 8'h00);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    check("start_busy", busy_o, 1);
    check("start_cnt", cnt_o, 0);
    for (int i = 0; i < CL; i++) begin
      step(1'b0, 1'b1, 8'h00, 1'b0);
      if (i == CL - 2) check("zero_not_done_early", done_o, 0);
    end
    check("zero_done", done_o, 1);
    check("zero_busy", busy_o, 0);
    check("zero_sig", sig_o, 8'h00);
    check("zero_cnt", cnt_o, CL);
    $display("[TB] zero window sig=%02h cnt=%0d", sig_o, cnt_o);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    check("zero_ack", done_o, 0);

    // Impulse window
    msig = 8'h00;
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < CL; i++) begin
      step(1'b0, 1'b1, (i == 0) ? 8'h01 : 8'h00, 1'b0);
      msig = gf_step(msig, (i == 0) ? 8'h01 : 8'h00);
      if (i == 0) check("impulse_latency", sig_o, 8'h01);
    end
    impulse_sig = msig;
    check("impulse_model", impulse_sig, 8'h26);
    check("impulse_sig", sig_o, 8'h26);
    check("impulse_done", done_o, 1);
    $display("[TB] impulse window sig=%02h", sig_o);
    step(1'b0, 1'b1, 8'h5A, 1'b0);
    check("done_holds_sig", sig_o, 8'h26);
    check("done_holds_cnt", cnt_o, CL);
    check("done_holds_done", done_o, 1);
    step(1'b0, 1'b0, 8'h00, 1'b1);

    // Gapped valid with a start pulse inside the window
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 31; i++) begin
      step(i == 5, (i % 2) == 0, (i == 0) ? 8'h01 : 8'h00, 1'b0);
      if (i == 5) check("start_ignored_cnt", cnt_o, 3);
      if (i == 29) check("gapped_not_done_at_30", done_o, 0);
    end
    check("gapped_done_at_31", done_o, 1);
    check("gapped_sig", sig_o, 8'h26);
    check("gapped_cnt", cnt_o, CL);
    $display("[TB] gapped window sig=%02h", sig_o);

    // start and ack together in DONE: IDLE only
    step(1'b1, 1'b0, 8'h00, 1'b1);
    check("hs_done_cleared", done_o, 0);
    check("hs_no_restart", busy_o, 0);
    check("hs_sig_held", sig_o, 8'h26);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    check("hs_still_idle", busy_o, 0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    check("restart_busy", busy_o, 1);
    check("restart_seed", sig_o, 8'h00);
    check("restart_cnt", cnt_o, 0);
    $display("[TB] handshake restart sig=%02h", sig_o);
    // Finish this window so the randomized windows start from IDLE
    for (int i = 0; i < CL; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);

    random_window(100);
    random_window(60);
    random_window(25);

    // Asynchronous reset mid-window
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'($urandom_range(1, 255)), 1'b0);
    check("pre_reset_cnt", cnt_o, 5);
    #2;
    rst_ni = 1'b0;
    #1;
    check("async_rst_sig", sig_o, 8'h00);
    check("async_rst_cnt", cnt_o, 0);
    check("async_rst_busy", busy_o, 0);
    $display("[TB] mid-window reset sig=%02h cnt=%0d", sig_o, cnt_o);
    @(negedge clk_i);
    rst_ni = 1'b1;
    step(1'b0, 1'b1, 8'h33, 1'b0);
    check("post_reset_idle", busy_o, 0);

`ifdef MISR_SCAN_EN
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < CL; i++) step(1'b0, 1'b1, (i == 0) ? 8'h01 : 8'h00, 1'b0);
    check("scan_pre_sig", sig_o, 8'h26);
    for (int k = 0; k < 8; k++) begin
      check("scan_o_bit", scan_o, impulse_sig[7-k]);
      scan_en_i = 1'b1;
      scan_i = 1'b0;
      step(1'b0, 1'b1, 8'hFF, 1'b1);
      $display("[TB] scan shift %0d sig=%02h", k, sig_o);
    end
    scan_en_i = 1'b0;
    check("scan_sig_after", sig_o, 8'h00);
    check("scan_fsm_frozen", done_o, 1);
    check("scan_cnt_frozen", cnt_o, CL);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/misr_capture.md
Name: misr_capture

Overview:
- Multiple-input signature register (MISR) that sits downstream of the merged combinational cells (a22o/o22a family) on the cell-library test board.
- Samples a Width-bit vector of merged-cell outputs on each valid cycle for a programmed window and compresses the samples into one signature.
- The signature is compared off-chip against a golden value, so board-level checking of merged cells needs no full output trace.

Parameters:
- Width, 8, bits of data_i and signature
- Poly, 8'h1D, Galois feedback polynomial (Width bits, x^Width implicit)
- Seed, 8'h00, signature value loaded on start
- CaptureLen, 16, number of valid samples per window (>=1)

Ports:
- clk_i  input  1  clock, rising edge
- rst_ni  input  1  reset, asynchronous, active-low
- start_i  input  1  begin a capture window (accepted only in IDLE)
- valid_i  input  1  data_i holds a sample this cycle
- data_i  input  Width  merged-cell outputs to compress
- ack_i  input  1  consumer has read sig_o; leave DONE
- busy_o  output  1  high in CAPTURE
- done_o  output  1  high in DONE
- sig_o  output  Width  current signature
- cnt_o  output  $clog2(CaptureLen+1)  samples taken in the current window

Behaviour:
- Reset:
  - Asynchronous, rst_ni=0 sets state=IDLE, sig_o=Seed, cnt_o=0, busy_o=0, done_o=0.
  - Applies immediately, including mid-window; the partial signature is discarded.
- States: IDLE, CAPTURE, DONE. All outputs are registered or decoded from state; no combinational path from inputs to outputs.
- IDLE:
  - start_i=1 → next cycle state=CAPTURE, sig=Seed, cnt=0.
  - valid_i and ack_i are ignored.
- CAPTURE:
  - Each cycle with valid_i=1: sig <= {sig[Width-2:0],1'b0} ^ (sig[Width-1] ? Poly : 0) ^ data_i; cnt <= cnt+1.
  - valid_i=0: sig and cnt hold.
  - When the update makes cnt==CaptureLen, state=DONE on that same edge, so sig_o is final in the first DONE cycle.
  - start_i is ignored.
- Latency: the sample on edge k is reflected in sig_o after edge k.
- DONE:
  - sig_o, cnt_o and done_o hold.
  - ack_i=1 → IDLE next cycle; sig_o keeps its value until the next start.
  - start_i and ack_i both high in DONE → go to IDLE only; no restart that cycle.
- Boundaries:
  - CaptureLen=1: one valid sample moves CAPTURE→DONE.
  - cnt never exceeds CaptureLen; no wrap.
  - All arithmetic is Width-bit XOR; there are no carries.

Optional Feature:
- Macro: MISR_SCAN_EN.
- Defined:
  - Adds ports scan_en_i (input 1), scan_i (input 1), scan_o (output 1, = sig[Width-1]).
  - scan_en_i=1 in any state: sig <= {sig[Width-2:0], scan_i}. The FSM, cnt and compression are frozen that cycle.
  - Allows serial readout and seeding through a single board pin.
- Undefined:
  - No scan ports.
  - sig changes only through start and compression.

Decomposition:
- Package misr_pkg holds:
  - state enum misr_state_e {IDLE, CAPTURE, DONE}
  - default polynomial and seed constants
  - function misr_next(sig, data, poly)
- One sub-module, misr_reg: the Width-bit signature register with load-seed, compress-enable and (under MISR_SCAN_EN) shift-enable.
- The FSM and counter stay in misr_capture.

Test Plan:
- Reset mid-window: after 5 valid samples, pull rst_ni low between edges → sig_o=8'h00, cnt_o=0, busy_o=0 immediately, with no clock needed.
- Zero data: start, 16 samples of 8'h00 → done_o=1 after the 16th sample edge, sig_o=8'h00, cnt_o=16.
- Impulse: start, sample 8'h01, then 15 samples of 8'h00 → sig_o=8'h26 in DONE.
- Gapped valid: same impulse pattern with valid_i low on alternate cycles → identical sig_o=8'h26, done after 31 CAPTURE cycles.
- Handshake: start_i pulsed during CAPTURE ignored; in DONE, start_i=ack_i=1 → IDLE, sig_o held; a second start reloads Seed.
- MISR_SCAN_EN: with sig_o=8'h26, scan_en_i=1 for 8 cycles with scan_i=0 → scan_o sequence 0,0,1,0,0,1,1,0 (MSB first), sig_o=8'h00 afterwards.
